// File: rtl/xeng_window_ctrl.sv
// xeng_window_ctrl: frames upstream samples into antenna blocks and windows for the X-engine cmac.
module xeng_window_ctrl #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS = 32,
  parameter int ANT_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                arm,
  input  logic                sync_in,
  input  logic                din_valid,
  output logic                acc_first,
  output logic                acc_last,
  output logic                valid_out,
  output logic [ANT_BITS-1:0] ant_idx,
  output logic                win_done,
  output logic [15:0]         win_count,
  output logic                sync_err,
  output logic                running
);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;
  state_t state;
  logic [SERIAL_ACC_LEN_BITS-1:0] sample_cnt, cur_s;
  logic [ANT_BITS-1:0] ant_cnt, cur_a;
  logic acc, resync, misalign, blk_end, win_end;
  assign acc      = din_valid & (state == RUN);
  assign resync   = sync_in & (state == RUN);
  assign misalign = resync & ((sample_cnt != '0) | (ant_cnt != '0));
  // a sync coinciding with a sample realigns first, so that sample is sample 0 of antenna 0
  assign cur_s    = resync ? '0 : sample_cnt;
  assign cur_a    = resync ? '0 : ant_cnt;
  assign blk_end  = &cur_s;
  assign win_end  = blk_end & (cur_a == ANT_BITS'(N_ANTS - 1));
  assign running  = (state == RUN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      ant_cnt    <= '0;
      acc_first  <= 1'b0;
      acc_last   <= 1'b0;
      valid_out  <= 1'b0;
      ant_idx    <= '0;
      win_done   <= 1'b0;
      win_count  <= '0;
      sync_err   <= 1'b0;
    end else if (ce) begin
      acc_first <= acc & (cur_s == '0);
      acc_last  <= acc & blk_end;
      valid_out <= acc;
      win_done  <= acc & win_end;
      sync_err  <= misalign;
      if (acc) ant_idx <= cur_a;
      if (acc & win_end) win_count <= win_count + 16'd1;
      if (state == IDLE) begin
        if (arm) state <= WAIT_SYNC;
      end else if (state == WAIT_SYNC) begin
        if (!arm) state <= IDLE;
        else if (sync_in) begin
          state      <= RUN;
          sample_cnt <= '0;
          ant_cnt    <= '0;
        end
      end else if (state == RUN) begin
        if (acc) begin
          sample_cnt <= cur_s + 1'b1;
          ant_cnt    <= win_end ? '0 : blk_end ? cur_a + 1'b1 : cur_a;
          if (win_end & !arm) state <= IDLE;
        end else if (resync) begin
          sample_cnt <= '0;
          ant_cnt    <= '0;
        end
      end else state <= IDLE;
    end
  end
endmodule

// File: doc/xeng_window_ctrl.md
XENG_WINDOW_CTRL -- requirements
Module: xeng_window_ctrl

Interface
REQ-001 SHALL have parameter SERIAL_ACC_LEN_BITS, default 7, log2 of the serial accumulation length per antenna block (LEN = 2^SERIAL_ACC_LEN_BITS).
REQ-002 SHALL have parameter N_ANTS, default 32, the number of dual-pol antenna blocks per window (range 2..256).
REQ-003 SHALL have parameter ANT_BITS, default 5, the counter width for antenna index (2^ANT_BITS >= N_ANTS).
REQ-004 SHALL have port clk  in  1  clock (all logic on rising edge).
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port ce  in  1  clock enable; when low, all state and outputs hold.
REQ-007 SHALL have port arm  in  1  level; requests windowing to run.
REQ-008 SHALL have port sync_in  in  1  single-cycle window-alignment pulse from upstream.
REQ-009 SHALL have port din_valid  in  1  upstream sample valid.
REQ-010 SHALL have port acc_first  out  1  first sample of an antenna block (cmac clears accumulator).
REQ-011 SHALL have port acc_last  out  1  last sample of an antenna block (cmac result valid next).
REQ-012 SHALL have port valid_out  out  1  registered copy of an accepted sample.
REQ-013 SHALL have port ant_idx  out  ANT_BITS  antenna index of the current sample.
REQ-014 SHALL have port win_done  out  1  one-cycle pulse on the last sample of a window.
REQ-015 SHALL have port win_count  out  16  completed windows since reset, wraps at 2^16.
REQ-016 SHALL have port sync_err  out  1  one-cycle pulse on a misaligned sync.
REQ-017 SHALL have port running  out  1  high while in state RUN.

Function
REQ-018 SHALL implement states IDLE, WAIT_SYNC, RUN; "accepted" = ce & din_valid & state==RUN.
REQ-019 SHALL go IDLE->WAIT_SYNC when ce & arm; WAIT_SYNC->RUN when ce & sync_in; WAIT_SYNC->IDLE when ce & !arm.
REQ-020 SHALL, on entering RUN, zero sample_cnt and ant_idx; the sync cycle itself is not a sample.
REQ-021 SHALL in RUN increment sample_cnt per accepted sample; at LEN-1 wrap to 0 and increment ant_idx.
REQ-022 SHALL wrap ant_idx from N_ANTS-1 to 0 (not 2^ANT_BITS-1) and pulse win_done, incrementing win_count.
REQ-023 SHALL register acc_first (sample_cnt==0), acc_last (sample_cnt==LEN-1), valid_out and ant_idx with exactly 1 cycle latency from the accepted sample.
REQ-024 SHALL hold counters and drive acc_first/acc_last/valid_out/win_done low on cycles with din_valid low (gaps allowed).
REQ-025 SHALL, on sync_in in RUN with counters both zero (window boundary), stay in RUN, no error.
REQ-026 SHALL, on sync_in in RUN with counters nonzero, pulse sync_err, zero counters, stay in RUN; no win_done.
REQ-027 SHALL treat sync_in coincident with an accepted sample as resync first: that sample becomes sample 0 of antenna 0.
REQ-028 SHALL, when arm drops in RUN, finish the current window, then go IDLE after the win_done cycle.
REQ-029 SHALL ignore arm and sync_in when ce is low.

Reset
REQ-030 SHALL on rst_n low asynchronously enter IDLE, zero counters and win_count, and drive all outputs 0.
REQ-031 SHALL, after rst_n deasserts mid-window, require a fresh arm and sync_in before any valid_out.

Verification
REQ-032 LEN=4, N_ANTS=3: arm, sync, 12 contiguous valids -> acc_first on samples 0,4,8; acc_last on 3,7,11; ant_idx 0,1,2; one win_done; win_count=1.
REQ-033 Same, din_valid 50% random gaps -> identical output sequence compressed to accepted cycles, latency 1.
REQ-034 sync_in after sample 5 -> sync_err one pulse, next sample has acc_first=1, ant_idx=0; no win_done.
REQ-035 arm dropped at sample 2 -> 12 samples still output, win_done, running=0 next cycle, further valids ignored.
REQ-036 rst_n low at sample 6 -> outputs 0 immediately; win_count=0; no valid_out until re-arm plus sync.
REQ-037 ce low for 3 cycles mid-block with din_valid high -> counters and outputs frozen, resume unchanged.
